serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 156 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller driving an external 1-bit full adder
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Full-adder operands are only presented while shifting; otherwise held quiet at 0.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_q == RUN) begin
      fa_a   = a_sr_q[0];
      fa_b   = b_sr_q[0];
      fa_cin = carry_q;
    end
  end

  // Next-state and datapath: load on start, shift LSB-first in RUN, publish result on the final edge.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = op_a;
          b_sr_d  = op_b;
          carry_d = cin_init;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last bit: carry_q still holds the carry into the MSB here.
          sum_d   = sum_sr_d;
          cout_d  = fa_cout;
          done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized self-checking bench for serial_adder_ctrl with a reference full adder
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin_init;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic [W-1:0] sum;
  logic         cout, busy, done;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .cin_init(cin_init),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference 1-bit full adder
  assign {fa_cout, fa_sum} = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_cin};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W-1:0] low;
    logic [W:0]   full;
    low  = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + W'(c);
    full = ref_add(a, b, c);
    return low[W-1] ^ full[W];
  endfunction

  // Start is driven after "edge 0"; it is accepted at edge 1, done expected after edge W+1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit meddle, input bit rel_rst);
    int bcnt = 0, dcnt = 0, didx = -1;
    logic moved = 1'b0;
    logic [W-1:0] prev;
    logic [W:0] e;
    e = ref_add(a, b, c);
    @(negedge clk);
    if (rel_rst) rst_n = 1'b1;
    start = 1'b1; op_a = a; op_b = b; cin_init = c;
    @(posedge clk); #1;
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); cin_init = 1'($urandom);
    prev = sum;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy) begin
        bcnt++;
        if (sum !== prev) moved = 1'b1;
      end
      if (done) begin
        dcnt++;
        didx = k;
      end
      if (meddle && k == 3) begin
        start = 1'b1; op_a = W'($urandom); op_b = W'($urandom); cin_init = 1'($urandom);
      end
      if (meddle && k == 4) start = 1'b0;
    end
    chk("busy_cycles", bcnt, W);
    chk("done_index", didx, W + 1);
    chk("done_count", dcnt, 1);
    chk("sum_stable_in_run", {31'd0, moved}, 0);
    chk("sum", {24'd0, sum}, {24'd0, e[W-1:0]});
    chk("cout", {31'd0, cout}, {31'd0, e[W]});
    chk("fa_idle", {29'd0, fa_a, fa_b, fa_cin}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, ref_ovf(a, b, c)});
`endif
  endtask

  task automatic reset_mid_run();
    int dcnt = 0;
    @(negedge clk);
    start = 1'b1; op_a = 8'hC3; op_b = 8'h5F; cin_init = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_rst", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("busy_in_rst", {31'd0, busy}, 0);
    chk("sum_in_rst", {24'd0, sum}, 0);
    chk("fa_in_rst", {29'd0, fa_a, fa_b, fa_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_abort", dcnt, 0);
    chk("sum_after_abort", {24'd0, sum}, 0);
    chk("cout_after_abort", {31'd0, cout}, 0);
    @(negedge clk);
    rst_n = 1'b0;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic continuous_start();
    int dcnt = 0, last = -1;
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] e;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    e = ref_add(a, b, c);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cin_init = c;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (last < 0) chk("cont_first_done", k, W + 1);
        else chk("cont_period", k - last, W + 2);
        chk("cont_sum", {23'd0, cout, sum}, {23'd0, e});
        last = k;
      end
    end
    start = 1'b0;
    chk("cont_done_count", dcnt, 4);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin_init = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sum", {24'd0, sum}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 0);
`endif
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(8'hA5, 8'h1E, 1'b1, 1'b1, 1'b0);
    reset_mid_run();
    continuous_start();
    for (int i = 0; i < 30; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
